// File: rtl/retire_monitor.sv
// retire_monitor: retirement trace consumer with perf counters, control-flow PC FIFO and halt detection
module retire_monitor #(
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int HALT_REPEAT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic [31:0] i_pc_debug,
    input  logic        i_ctrl,
    input  logic        i_mispred,
    input  logic        i_clr,
    input  logic [1:0]  i_rd_sel,
    output logic [31:0] o_rd_data,
    output logic        o_trace_valid,
    output logic [31:0] o_trace_pc,
    input  logic        i_trace_ready,
    output logic        o_overflow,
    output logic        o_halted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cyc, instret, ctrl_cnt, mispred_cnt, sel_cnt;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [31:0]      last_pc;
    logic             last_vld;
    logic [RW-1:0]    rep_cnt, rep_nxt;
    logic             push, pop, full, accept, same_pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return v + CNT_W'(en && v != CMAX);
    endfunction

    // FIFO status, halt-detector next repeat count and read mux
    always_comb begin
        push          = i_insn_vld & i_ctrl;
        o_trace_valid = wr_ptr != rd_ptr;
        pop           = o_trace_valid & i_trace_ready;
        full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
        accept        = push & (~full | pop);
        o_trace_pc    = o_trace_valid ? mem[rd_ptr[AW-1:0]] : 32'h0;
        same_pc       = last_vld & (i_pc_debug == last_pc);
        rep_nxt       = !same_pc ? RW'(1) : (rep_cnt == RW'(HALT_REPEAT)) ? rep_cnt : rep_cnt + RW'(1);
        sel_cnt       = i_rd_sel == 2'd0 ? cyc :
                        i_rd_sel == 2'd1 ? instret :
                        i_rd_sel == 2'd2 ? ctrl_cnt : mispred_cnt;
    end

    // Saturating performance counters and registered read port
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cyc         <= '0;
            instret     <= '0;
            ctrl_cnt    <= '0;
            mispred_cnt <= '0;
            o_rd_data   <= '0;
        end else if (i_clr) begin
            cyc         <= '0;
            instret     <= '0;
            ctrl_cnt    <= '0;
            mispred_cnt <= '0;
            o_rd_data   <= '0;
        end else begin
            cyc         <= sat_inc(cyc, !o_halted);
            instret     <= sat_inc(instret, i_insn_vld);
            ctrl_cnt    <= sat_inc(ctrl_cnt, push);
            mispred_cnt <= sat_inc(mispred_cnt, i_mispred);
            o_rd_data   <= 32'(sel_cnt);
        end
    end

    // Trace storage; contents need no reset because pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (accept && !i_clr) mem[wr_ptr[AW-1:0]] <= i_pc_debug;
    end

    // FIFO pointers and sticky overflow on a dropped push
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else if (i_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= accept ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
            o_overflow <= o_overflow | (push & full & ~pop);
        end
    end

    // Same-PC repeat tracking; bubbles leave it untouched, halt is sticky
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            rep_cnt  <= '0;
            o_halted <= 1'b0;
        end else if (i_clr) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
            rep_cnt  <= '0;
            o_halted <= 1'b0;
        end else if (i_insn_vld) begin
            last_pc  <= i_pc_debug;
            last_vld <= 1'b1;
            rep_cnt  <= rep_nxt;
            o_halted <= o_halted | (rep_nxt == RW'(HALT_REPEAT));
        end
    end
endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: directed and randomized checks of retire_monitor against a queue-based model
module tb_retire_monitor;
    localparam int DEPTH = 8;
    localparam int HR    = 4;
    localparam int MAXC  = 255;

    logic        clk = 0, rst_n = 1, vld = 0, ctrl = 0, misp = 0, clr = 0, rdy = 0;
    logic [31:0] pc = 0;
    logic [1:0]  sel = 0;
    logic [31:0] rd_data, t_pc;
    logic        t_valid, ovf, halted;

    retire_monitor #(.CNT_W(8), .FIFO_DEPTH(DEPTH), .HALT_REPEAT(HR)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_insn_vld(vld), .i_pc_debug(pc), .i_ctrl(ctrl),
        .i_mispred(misp), .i_clr(clr), .i_rd_sel(sel), .o_rd_data(rd_data),
        .o_trace_valid(t_valid), .o_trace_pc(t_pc), .i_trace_ready(rdy),
        .o_overflow(ovf), .o_halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: plain integers, a queue and the repeat rule
    int          m_cnt[4];
    logic [31:0] m_q[$];
    bit          m_ovf, m_halt, m_lv;
    logic [31:0] m_last, m_rd;
    int          m_rep;

    function automatic void m_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_q.delete();
        m_ovf = 0; m_halt = 0; m_lv = 0; m_last = 0; m_rep = 0; m_rd = 0;
    endfunction

    function automatic int sat(input int v);
        return v < MAXC ? v + 1 : v;
    endfunction

    function automatic void m_step();
        bit p_pop, p_push;
        if (clr) begin
            m_reset();
            return;
        end
        m_rd   = m_cnt[sel];
        p_pop  = m_q.size() > 0 && rdy;
        p_push = vld && ctrl;
        if (p_push && m_q.size() == DEPTH && !p_pop) m_ovf = 1;
        else begin
            if (p_pop) void'(m_q.pop_front());
            if (p_push) m_q.push_back(pc);
        end
        if (!m_halt) m_cnt[0] = sat(m_cnt[0]);
        if (vld) m_cnt[1] = sat(m_cnt[1]);
        if (vld && ctrl) m_cnt[2] = sat(m_cnt[2]);
        if (misp) m_cnt[3] = sat(m_cnt[3]);
        if (vld) begin
            if (m_lv && pc == m_last) m_rep = m_rep < HR ? m_rep + 1 : HR;
            else begin
                m_rep  = 1;
                m_last = pc;
            end
            m_lv = 1;
            if (m_rep == HR) m_halt = 1;
        end
    endfunction

    task automatic check_outs();
        chk("valid", 32'(t_valid), 32'(m_q.size() > 0));
        chk("trace_pc", t_pc, m_q.size() > 0 ? m_q[0] : 32'h0);
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("rd_data", rd_data, m_rd);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_step();
        else m_reset();
        #1;
        check_outs();
    endtask

    task automatic quiet();
        vld = 0; ctrl = 0; misp = 0; clr = 0; rdy = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        m_reset();
        check_outs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic do_clr();
        quiet();
        clr = 1;
        tick();
        clr = 0;
    endtask

    task automatic retire(input logic [31:0] p, input logic c);
        vld = 1; pc = p; ctrl = c;
        tick();
        vld = 0; ctrl = 0;
    endtask

    task automatic drain_expect(input logic [31:0] exp);
        chk("drain_head", t_pc, exp);
        rdy = 1;
        tick();
        rdy = 0;
    endtask

    initial begin
        #2;
        do_reset();
        // some activity, then reset mid-run and idle
        for (int i = 0; i < 5; i++) retire(32'h900 + 32'(i) * 4, 1'b1);
        do_reset();
        chk("rst_valid", 32'(t_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        sel = 0;
        for (int i = 0; i < 10; i++) tick();
        tick();
        chk("idle_cyc", rd_data, 10);
        sel = 1;
        tick();
        chk("idle_instret", rd_data, 0);

        // count mix
        do_clr();
        for (int i = 0; i < 6; i++) begin
            misp = (i == 2);
            retire(32'h1000 + 32'(i) * 4, i == 1 || i == 4);
            misp = 0;
        end
        sel = 1; tick(); chk("mix_instret", rd_data, 6);
        sel = 2; tick(); chk("mix_ctrl", rd_data, 2);
        sel = 3; tick(); chk("mix_mispred", rd_data, 1);
        drain_expect(32'h1004);
        drain_expect(32'h1010);
        chk("mix_empty", 32'(t_valid), 0);

        // full and overflow
        do_clr();
        for (int i = 0; i < 9; i++) retire(32'h100 + 32'(i) * 4, 1'b1);
        chk("full_ovf", 32'(ovf), 1);
        for (int i = 0; i < 8; i++) drain_expect(32'h100 + 32'(i) * 4);
        chk("full_drained", 32'(t_valid), 0);

        // push and pop in the same cycle while full
        do_clr();
        for (int i = 0; i < 8; i++) retire(32'h300 + 32'(i) * 4, 1'b1);
        vld = 1; ctrl = 1; pc = 32'h200; rdy = 1;
        tick();
        quiet();
        chk("pp_no_ovf", 32'(ovf), 0);
        for (int i = 1; i < 8; i++) drain_expect(32'h300 + 32'(i) * 4);
        drain_expect(32'h200);
        chk("pp_empty", 32'(t_valid), 0);

        // halt on four retirements of the same PC with bubbles
        do_clr();
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            retire(32'h40, 1'b0);
            if (i < 3) tick();
        end
        chk("halt_set", 32'(halted), 1);
        tick(); chk("cyc_frozen_a", rd_data, 7);
        tick(); tick(); chk("cyc_frozen_b", rd_data, 7);
        do_clr();
        retire(32'h40, 1'b0); retire(32'h44, 1'b0); retire(32'h40, 1'b0);
        tick(); tick();
        chk("no_halt", 32'(halted), 0);

        // saturation then clear with a concurrent push
        do_clr();
        misp = 1;
        for (int i = 0; i < 300; i++) tick();
        misp = 0;
        sel = 3;
        tick();
        chk("misp_sat", rd_data, 255);
        vld = 1; ctrl = 1; pc = 32'h500; clr = 1;
        tick();
        quiet();
        chk("clr_valid", 32'(t_valid), 0);
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_halt", 32'(halted), 0);
        chk("clr_rd", rd_data, 0);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            chk("clr_cnt", rd_data, 0);
        end

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            vld  = $urandom_range(0, 1);
            ctrl = $urandom_range(0, 2) == 0;
            pc   = $urandom_range(0, 5) == 0 ? $urandom : 32'h40 + 32'($urandom_range(0, 2)) * 4;
            misp = $urandom_range(0, 3) == 0;
            rdy  = $urandom_range(0, 2) == 0;
            sel  = 2'($urandom_range(0, 3));
            clr  = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 999) == 0) do_reset();
            else tick();
        end
        quiet();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
